// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART baud generator, transmitter,
// receiver and the transmit scheduler.
package uart_pkg;

    // Character format defaults; every UART block must agree on these.
    localparam int DEF_DATABITS    = 8;
    localparam int DEF_FRAME_TICKS = 11;

    // Transmit scheduler states: waiting for a request, or a frame on the line.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } tx_sched_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational winner select for the transmit scheduler.
// Build option UART_TX_SCHED_FIXED_PRIO_EN: when defined, the lowest-index
// requester always wins and the pointer input disappears.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
    input  logic [IDW-1:0]     ptr_i,
`endif
    output logic               any_o,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDW-1:0]     win_idx_o
);

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    // Scan from the top down so the lowest requesting index is the last writer.
    always_comb begin
        any_o     = 1'b0;
        win_o     = '0;
        win_idx_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_o     = 1'b1;
                win_o     = '0;
                win_o[i]  = 1'b1;
                win_idx_o = IDW'(i);
            end
        end
    end
`else
    int                 slot;
    logic [IDW-1:0]     slotIdx;

    // Visit the rotated positions farthest-first so the slot nearest the
    // pointer overrides any earlier candidate.
    always_comb begin
        any_o     = 1'b0;
        win_o     = '0;
        win_idx_o = '0;
        slot      = 0;
        slotIdx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = int'(ptr_i) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            slotIdx = IDW'(slot);
            if (req_i[slotIdx]) begin
                any_o          = 1'b1;
                win_o          = '0;
                win_o[slotIdx] = 1'b1;
                win_idx_o      = slotIdx;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter among NUM_REQ byte sources.
// Owns the transmitter's start/data inputs and times each frame in baud ticks.
// Build option UART_TX_SCHED_FIXED_PRIO_EN selects fixed priority instead of
// round-robin; handshake and timing are the same either way.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATABITS    = DEF_DATABITS,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         baud_tick,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATABITS-1:0]  req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         tx_start,
    output logic [DATABITS-1:0]          tx_data,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   active_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FRAME_TICKS + 2);
    // The frame ends on the tick that would take the count to FRAME_TICKS+1;
    // one tick beyond the frame covers the transmitter syncing to its next tick.
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_TICKS);

    tx_sched_state_e       state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATABITS-1:0]   tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic [IDW-1:0]        active_id_q, active_id_d;

    logic                  anyReq;
    logic [NUM_REQ-1:0]    winOneHot;
    logic [IDW-1:0]        winIdx;

`ifndef UART_TX_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0]        ptr_q, ptr_d;
`endif

    uart_rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .req_i     (req),
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
        .ptr_i     (ptr_q),
`endif
        .any_o     (anyReq),
        .win_o     (winOneHot),
        .win_idx_o (winIdx)
    );

    // Next-state logic: capture a winner from IDLE, then count ticks in FRAME.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        active_id_d = active_id_q;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d     = FRAME;
                    cnt_d       = '0;
                    grant_d     = winOneHot;
                    tx_start_d  = 1'b1;
                    busy_d      = 1'b1;
                    tx_data_d   = req_data[int'(winIdx)*DATABITS +: DATABITS];
                    active_id_d = winIdx;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
                    ptr_d       = (winIdx == IDW'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
`endif
                end
            end
            FRAME: begin
                // A tick landing in the start cycle predates the frame itself.
                if (baud_tick && !tx_start_q) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios plus randomized traffic for the UART
// transmit scheduler, checked against a transaction-level model of the bench.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int FT = 11;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              baud_tick = 1'b0;
    logic [N-1:0]      req       = '0;
    logic [N*DB-1:0]   req_data  = '0;
    logic [N-1:0]      grant;
    logic              tx_start;
    logic [DB-1:0]     tx_data;
    logic              busy;
    logic [1:0]        active_id;

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 1'b0;

    // Reference model state: what the outputs must be in the current cycle.
    logic [N-1:0]  mGrant     = '0;
    logic          mTxStart   = 1'b0;
    logic [DB-1:0] mTxData    = '0;
    logic          mBusy      = 1'b0;
    int            mActive    = 0;
    int            mPtr       = 0;
    int            mTicksLeft = 0;

    uart_tx_sched #(
        .NUM_REQ     (N),
        .DATABITS    (DB),
        .FRAME_TICKS (FT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge and hold until the next falling edge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*DB-1:0] d, input logic t);
        req       = r;
        req_data  = d;
        baud_tick = t;
        @(negedge clk);
    endtask

    function automatic int pickWinner(input logic [N-1:0] r, input int ptr);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
`endif
        return -1;
    endfunction

    function automatic int oneHotIndex(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    // Model: a frame owns the line for FRAME_TICKS+1 ticks counted after the start cycle.
    initial begin : model
        int w;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mGrant = '0; mTxStart = 1'b0; mTxData = '0; mBusy = 1'b0;
                mActive = 0; mPtr = 0; mTicksLeft = 0;
            end else if (mBusy) begin
                if (baud_tick && !mTxStart) begin
                    mTicksLeft--;
                    if (mTicksLeft == 0) mBusy = 1'b0;
                end
                mGrant   = '0;
                mTxStart = 1'b0;
            end else begin
                w = pickWinner(req, mPtr);
                mGrant   = '0;
                mTxStart = 1'b0;
                if (w >= 0) begin
                    mGrant[w]  = 1'b1;
                    mTxStart   = 1'b1;
                    mBusy      = 1'b1;
                    mTicksLeft = FT + 1;
                    mTxData    = req_data[w*DB +: DB];
                    mActive    = w;
                    mPtr       = (w + 1) % N;
                end
            end
        end
    end

    // Compare every output against the model in the middle of every cycle.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (checkEn && reset) begin
                checkOutput("grant",     32'(grant),     32'(mGrant));
                checkOutput("tx_start",  32'(tx_start),  32'(mTxStart));
                checkOutput("tx_data",   32'(tx_data),   32'(mTxData));
                checkOutput("busy",      32'(busy),      32'(mBusy));
                checkOutput("active_id", 32'(active_id), 32'(mActive));
            end
        end
    end

    task automatic drainFrame(input string name);
        int c;
        c = 0;
        while (busy === 1'b1 && c < 200) begin
            applyStimulus('0, req_data, 1'b1);
            c++;
        end
        checkOutput(name, 32'(busy), 32'd0);
        applyStimulus('0, req_data, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus('0, '0, 1'b0);
        applyStimulus('0, '0, 1'b0);
        reset = 1'b1;
        applyStimulus('0, '0, 1'b0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [N*DB-1:0] d;
        logic [N-1:0]    r;
        int  ticks, cyc, nGrant, firstG, secondG, idx;
        bit  sawGrant, stable;
        int  got[5];
        int  expOrder[5];

        repeat (3) @(negedge clk);
        checkOutput("rst_grant",     32'(grant),     32'd0);
        checkOutput("rst_tx_start",  32'(tx_start),  32'd0);
        checkOutput("rst_tx_data",   32'(tx_data),   32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_active_id", 32'(active_id), 32'd0);
        reset   = 1'b1;
        checkEn = 1'b1;
        applyStimulus('0, '0, 1'b0);

        // Single request from client 1, with a tick in the start cycle.
        d = '0;
        d[15:8] = 8'hA5;
        applyStimulus(4'b0010, d, 1'b0);
        checkOutput("single_grant",     32'(grant),     32'h2);
        checkOutput("single_tx_start",  32'(tx_start),  32'd1);
        checkOutput("single_tx_data",   32'(tx_data),   32'hA5);
        checkOutput("single_active_id", 32'(active_id), 32'd1);
        checkOutput("single_busy",      32'(busy),      32'd1);
        applyStimulus('0, d, 1'b1);
        ticks = 0;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (cyc[0]) ticks++;
            applyStimulus('0, d, cyc[0]);
            cyc++;
        end
        checkOutput("single_busy_drops", 32'(busy), 32'd0);
        checkOutput("single_tick_count", 32'(ticks), 32'd12);
        applyStimulus('0, d, 1'b0);

        // Client 2 arrives mid-frame, client 3 comes and goes during the frame.
        d = 32'h773C0011;
        applyStimulus(4'b0001, d, 1'b0);
        checkOutput("mid_first_grant", 32'(grant), 32'h1);
        applyStimulus('0, d, 1'b1);
        sawGrant = 1'b0;
        stable   = 1'b1;
        cyc      = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (grant !== '0) sawGrant = 1'b1;
            if (tx_data !== 8'h11) stable = 1'b0;
            r = '0;
            if (cyc >= 2) r[2] = 1'b1;
            if (cyc >= 3 && cyc < 8) r[3] = 1'b1;
            applyStimulus(r, d, 1'b1);
            cyc++;
        end
        checkOutput("mid_no_grant_in_frame", 32'(sawGrant), 32'd0);
        checkOutput("mid_txdata_stable",     32'(stable),   32'd1);
        checkOutput("mid_busy_drops",        32'(busy),     32'd0);
        applyStimulus(4'b0100, d, 1'b0);
        checkOutput("mid_late_grant",   32'(grant),     32'h4);
        checkOutput("mid_late_data",    32'(tx_data),   32'h3C);
        checkOutput("mid_late_id",      32'(active_id), 32'd2);
        drainFrame("mid_drain");

        // Pointer follows client 2's grant only; the withdrawal left no trace.
        applyStimulus(4'b1011, d, 1'b0);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        checkOutput("ptr_after_withdraw", 32'(grant), 32'h1);
`else
        checkOutput("ptr_after_withdraw", 32'(grant), 32'h8);
`endif
        drainFrame("ptr_drain");

        // All four clients requesting continuously from a reset pointer.
        doReset();
        d = 32'h44332211;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0, 0};
`else
        expOrder = '{0, 1, 2, 3, 0};
`endif
        got     = '{-1, -1, -1, -1, -1};
        nGrant  = 0;
        firstG  = -1;
        secondG = -1;
        cyc     = 0;
        while (nGrant < 5 && cyc < 400) begin
            applyStimulus(4'b1111, d, 1'b1);
            if (grant !== '0) begin
                idx = oneHotIndex(grant);
                got[nGrant] = idx;
                if (nGrant == 0) firstG = cyc;
                if (nGrant == 1) secondG = cyc;
                nGrant++;
            end
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("all4_order_%0d", k), 32'(got[k]), 32'(expOrder[k]));
        end
        checkOutput("all4_gap", 32'(secondG - firstG), 32'd14);
        drainFrame("all4_drain");

        // Reset in the middle of a frame after five counted ticks.
        applyStimulus(4'b0100, d, 1'b0);
        checkOutput("rstmid_grant", 32'(grant), 32'h4);
        applyStimulus('0, d, 1'b1);
        repeat (5) applyStimulus('0, d, 1'b1);
        checkOutput("rstmid_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rstmid_grant0",    32'(grant),     32'd0);
        checkOutput("rstmid_tx_start0", 32'(tx_start),  32'd0);
        checkOutput("rstmid_tx_data0",  32'(tx_data),   32'd0);
        checkOutput("rstmid_busy0",     32'(busy),      32'd0);
        checkOutput("rstmid_id0",       32'(active_id), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(4'b1001, d, 1'b0);
        checkOutput("rstmid_after_grant", 32'(grant),     32'h1);
        checkOutput("rstmid_after_id",    32'(active_id), 32'd0);
        checkOutput("rstmid_after_data",  32'(tx_data),   32'h11);
        drainFrame("rstmid_drain");

        // Randomized clients: hold until granted, occasionally withdraw or re-request.
        r = '0;
        d = req_data;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (mGrant[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        r[i] = 1'b1;
                        d[i*DB +: DB] = 8'($urandom);
                    end else begin
                        r[i] = 1'b0;
                    end
                end else if (r[i]) begin
                    if ($urandom_range(29, 0) == 0) r[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    r[i] = 1'b1;
                    d[i*DB +: DB] = 8'($urandom);
                end
            end
            applyStimulus(r, d, ($urandom_range(2, 0) == 0));
        end
        drainFrame("random_drain");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
